// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - credit-based instruction fetch stage with in-order response queue
//
// Issues word-addressed fetch requests over a valid/ready handshake, accepts
// in-order responses of any latency and buffers them with their PCs in a
// DEPTH-entry circular queue that feeds decode. A redirect squashes the queue
// and turns every in-flight request into a response that will be dropped.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   redirect_i/_pc_i        squash and refetch from redirect_pc_i
//   imem_req_*              fetch request (valid/ready, word address)
//   imem_rsp_*              fetch response (in order, always accepted)
//   de_valid_o/de_ready_i   queue head handshake towards decode
//   de_instr_o/de_pc_o      head instruction and its PC
//   de_pc_plus1_o           head PC + 1, wrapping
module fetch_queue_stage #(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_req_valid_o,
    input  logic               imem_req_ready_i,
    output logic [PC_W-1:0]    imem_req_addr_o,
    input  logic               imem_rsp_valid_i,
    input  logic [INSTR_W-1:0] imem_rsp_data_i,
    output logic               de_valid_o,
    input  logic               de_ready_i,
    output logic [INSTR_W-1:0] de_instr_o,
    output logic [PC_W-1:0]    de_pc_o,
    output logic [PC_W-1:0]    de_pc_plus1_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_n;
    logic [PC_W-1:0]    rsp_pc_q, rsp_pc_n;
    logic [CW-1:0]      outst_q, outst_n;
    logic [CW-1:0]      drop_q, drop_n;
    logic [CW-1:0]      count_q, count_n;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_n;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_n;
    logic               req_valid_q, req_valid_n;
    logic [CW+1:0]      credit_sum;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];

    logic               req_fire;
    logic               rsp_take;
    logic               push;
    logic               pop;

    assign imem_req_valid_o = req_valid_q;
    assign imem_req_addr_o  = fetch_pc_q;
    assign de_valid_o       = (count_q != '0);
    assign de_instr_o       = de_valid_o ? instr_mem[rd_ptr_q] : '0;
    assign de_pc_o          = de_valid_o ? pc_mem[rd_ptr_q] : '0;
    assign de_pc_plus1_o    = de_pc_o + PC_W'(1);

    always_comb begin
        req_fire = req_valid_q & imem_req_ready_i;
        // A response is kept only when no stale responses are still owed.
        rsp_take = imem_rsp_valid_i && (drop_q == '0);
        push     = rsp_take && !redirect_i;
        pop      = de_valid_o && de_ready_i;

        fetch_pc_n = fetch_pc_q;
        rsp_pc_n   = rsp_pc_q;
        outst_n    = outst_q;
        drop_n     = drop_q;
        count_n    = count_q;
        wr_ptr_n   = wr_ptr_q;
        rd_ptr_n   = rd_ptr_q;

        if (redirect_i) begin
            fetch_pc_n = redirect_pc_i;
            rsp_pc_n   = redirect_pc_i;
            outst_n    = '0;
            // Everything still in flight, including a request accepted this
            // cycle, must come back and be discarded.
            drop_n     = drop_q + outst_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
            count_n    = '0;
            wr_ptr_n   = '0;
            rd_ptr_n   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_n = fetch_pc_q + PC_W'(1);
            end
            if (imem_rsp_valid_i) begin
                if (drop_q != '0) begin
                    drop_n = drop_q - CW'(1);
                end else begin
                    rsp_pc_n = rsp_pc_q + PC_W'(1);
                end
            end
            outst_n  = outst_q + CW'(req_fire) - CW'(rsp_take);
            count_n  = count_q + CW'(push) - CW'(pop);
            wr_ptr_n = wr_ptr_q + AW'(push);
            rd_ptr_n = rd_ptr_q + AW'(pop);
        end

        // Registered credit check: every slot is reserved at request time, so
        // a pushed response can never find the queue full.
        credit_sum  = {2'b00, outst_n} + {2'b00, drop_n} + {2'b00, count_n};
        req_valid_n = (credit_sum < (CW+2)'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            outst_q     <= '0;
            drop_q      <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_n;
            rsp_pc_q    <= rsp_pc_n;
            outst_q     <= outst_n;
            drop_q      <= drop_n;
            count_q     <= count_n;
            wr_ptr_q    <= wr_ptr_n;
            rd_ptr_q    <= rd_ptr_n;
            req_valid_q <= req_valid_n;
        end
    end

    // Queue storage carries no reset; the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rsp_data_i;
            pc_mem[wr_ptr_q]    <= rsp_pc_q;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding means the memory broke the protocol.
    always_ff @(posedge clk) begin
        if (reset && imem_rsp_valid_i) begin
            assert (outst_q != '0 || drop_q != '0);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - directed self-checking bench for fetch_queue_stage
module tb_fetch_queue_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        de_valid_o;
    logic        de_ready_i;
    logic [31:0] de_instr_o;
    logic [31:0] de_pc_o;
    logic [31:0] de_pc_plus1_o;

    fetch_queue_stage #(.PC_W(32), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .de_valid_o       (de_valid_o),
        .de_ready_i       (de_ready_i),
        .de_instr_o       (de_instr_o),
        .de_pc_o          (de_pc_o),
        .de_pc_plus1_o    (de_pc_plus1_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit stale; } inf_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    mreq_t mq[$];
    inf_t  m_inf[$];
    ent_t  m_q[$];
    logic [31:0] m_fetch_pc;
    bit          m_fresh;
    bit          exp_rv;

    int errors = 0;
    int checks = 0;
    int cyc;
    int lat;
    bit mem_ready, de_rdy, redir;
    logic [31:0] redir_pc;

    bit          last_req_fire, last_pop;
    logic [31:0] last_req_addr, last_pop_pc;
    int          n_req;
    int          first_de_step;
    logic [31:0] first_de_pc;
    bit          watch_bad, bad, wrap_seen;
    bit          have_prev;
    logic [31:0] prev_addr;
    int          skips = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        exp_rv = !m_fresh && ((m_inf.size() + m_q.size()) < DEPTH);
        chk("req_valid", {63'd0, imem_req_valid_o}, {63'd0, exp_rv});
        chk("req_addr", {32'd0, imem_req_addr_o}, {32'd0, m_fetch_pc});
        chk("de_valid", {63'd0, de_valid_o}, {63'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("de_pc", {32'd0, de_pc_o}, {32'd0, m_q[0].pc});
            chk("de_instr", {32'd0, de_instr_o}, {32'd0, m_q[0].instr});
            chk("de_pc_plus1", {32'd0, de_pc_plus1_o}, {32'd0, m_q[0].pc + 32'd1});
        end
    endtask

    task automatic step();
        bit rsp_v, req_f, mreq, mpop;
        inf_t e;
        @(negedge clk);
        rsp_v            = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid_i = rsp_v;
        imem_rsp_data_i  = rsp_v ? mem_data(mq[0].addr) : 32'd0;
        imem_req_ready_i = mem_ready;
        de_ready_i       = de_rdy;
        redirect_i       = redir;
        redirect_pc_i    = redir_pc;
        #1;
        compare();

        req_f         = imem_req_valid_o && imem_req_ready_i;
        last_req_fire = req_f;
        last_pop      = de_valid_o && de_ready_i;
        last_pop_pc   = de_pc_o;
        if (req_f) begin
            last_req_addr = imem_req_addr_o;
            n_req++;
            if (have_prev && imem_req_addr_o != prev_addr + 32'd1) skips++;
            prev_addr = imem_req_addr_o;
            have_prev = 1;
        end
        if (de_valid_o && first_de_step < 0) begin
            first_de_step = cyc;
            first_de_pc   = de_pc_o;
        end
        if (watch_bad && de_valid_o && de_pc_o >= 32'd5 && de_pc_o <= 32'd8) bad = 1;
        if (de_valid_o && de_pc_o == 32'hFFFF_FFFF && de_pc_plus1_o == 32'd0) wrap_seen = 1;

        if (rsp_v) void'(mq.pop_front());
        if (req_f) mq.push_back('{imem_req_addr_o, cyc + lat});

        mpop = (m_q.size() != 0) && de_ready_i;
        mreq = exp_rv && imem_req_ready_i;
        if (mpop) void'(m_q.pop_front());
        if (rsp_v && m_inf.size() > 0) begin
            e = m_inf.pop_front();
            if (!e.stale && !redirect_i) m_q.push_back('{imem_rsp_data_i, e.pc});
        end
        if (mreq) begin
            m_inf.push_back('{m_fetch_pc, 1'b0});
            m_fetch_pc = m_fetch_pc + 32'd1;
        end
        if (redirect_i) begin
            foreach (m_inf[i]) m_inf[i].stale = 1'b1;
            m_q.delete();
            m_fetch_pc = redirect_pc_i;
            have_prev  = 0;
        end
        m_fresh = 0;
        redir   = 0;
        cyc++;
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        redir            = 0;
        redirect_i       = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'd0;
        #1;
        chk("rst_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
        chk("rst_req_addr", {32'd0, imem_req_addr_o}, 64'd0);
        chk("rst_de_valid", {63'd0, de_valid_o}, 64'd0);
        chk("rst_de_instr", {32'd0, de_instr_o}, 64'd0);
        chk("rst_de_pc", {32'd0, de_pc_o}, 64'd0);
        mq.delete();
        m_inf.delete();
        m_q.delete();
        m_fetch_pc    = 32'd0;
        m_fresh       = 1;
        cyc           = 0;
        first_de_step = -1;
        have_prev     = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        reset            = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = 32'd0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'd0;
        de_ready_i       = 1'b0;
        mem_ready = 1; de_rdy = 1; redir = 0; redir_pc = 32'd0; lat = 1;
        watch_bad = 0; bad = 0; wrap_seen = 0; n_req = 0;

        // Streaming at L=1: first entry visible in cycle 3, one per cycle.
        do_reset();
        for (int i = 0; i < 12; i++) step();
        chk("t1_first_de_cycle", first_de_step, 3);
        chk("t1_first_de_pc", {32'd0, first_de_pc}, 64'd0);

        // Decode stalled: exactly DEPTH requests, then drain and resume at 4.
        do_reset();
        de_rdy = 0; n_req = 0;
        for (int i = 0; i < 10; i++) step();
        chk("t2_req_count", n_req, DEPTH);
        chk("t2_req_valid_off", {63'd0, imem_req_valid_o}, 64'd0);
        chk("t2_head_pc", {32'd0, de_pc_o}, 64'd0);
        de_rdy = 1;
        last_req_fire = 0;
        for (int i = 0; i < 10 && !last_req_fire; i++) step();
        chk("t2_resume_addr", {32'd0, last_req_addr}, 64'd4);

        // Memory ready toggling: address must hold until accepted.
        begin
            bit pat [10] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1};
            for (int i = 0; i < 10; i++) begin
                mem_ready = pat[i];
                step();
            end
            mem_ready = 1;
            for (int i = 0; i < 6; i++) step();
        end
        chk("t3_no_skip", skips, 0);

        // L=3: redirect to 0x40 in the cycle PC 5 returns.
        lat = 3;
        do_reset();
        redir = 1; redir_pc = 32'd5;
        step();
        begin
            bit found = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (mq.size() > 0 && mq[0].addr == 32'd5 && mq[0].due <= cyc) found = 1;
                else step();
            end
            chk("t4_pc5_return", {63'd0, found}, 64'd1);
        end
        redir = 1; redir_pc = 32'h40;
        watch_bad = 1; bad = 0;
        step();
        first_de_step = -1;
        for (int i = 0; i < 25; i++) step();
        watch_bad = 0;
        chk("t4_first_pc", {32'd0, first_de_pc}, 64'h40);
        chk("t4_no_stale", {63'd0, bad}, 64'd0);

        // Redirect together with an accepted request and a pop.
        lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) step();
        redir = 1; redir_pc = 32'h100;
        step();
        chk("t5_pop_in_redirect", {63'd0, last_pop}, 64'd1);
        chk("t5_pop_pc", {32'd0, last_pop_pc}, 64'd5);
        chk("t5_req_in_redirect", {63'd0, last_req_fire}, 64'd1);
        de_rdy = 0; n_req = 0;
        for (int i = 0; i < 12; i++) step();
        chk("t5_credits_restored", n_req, DEPTH);
        chk("t5_head_pc", {32'd0, de_pc_o}, 64'h100);
        chk("t5_full_stall", {63'd0, imem_req_valid_o}, 64'd0);

        // PC wrap at the top of the address space.
        de_rdy = 1;
        redir = 1; redir_pc = 32'hFFFF_FFFE;
        wrap_seen = 0;
        for (int i = 0; i < 12; i++) step();
        chk("t6_wrap", {63'd0, wrap_seen}, 64'd1);

        // Asynchronous reset mid-cycle with entries queued and a request pending.
        do_reset();
        de_rdy = 0;
        for (int i = 0; i < 4; i++) step();
        chk("t7_pre_de_valid", {63'd0, de_valid_o}, 64'd1);
        chk("t7_pre_req_valid", {63'd0, imem_req_valid_o}, 64'd1);
        do_reset();
        last_req_fire = 0;
        for (int i = 0; i < 6 && !last_req_fire; i++) step();
        chk("t7_restart_fire", {63'd0, last_req_fire}, 64'd1);
        chk("t7_restart_addr", {32'd0, last_req_addr}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue_stage.md
# fetch_queue_stage

Parametrised fetch stage that decouples PC generation from decode. It issues word-addressed requests to an instruction memory over a valid/ready handshake, tolerates variable but in-order response latency, and buffers returned instructions with their PCs in a DEPTH-entry queue feeding DE. A redirect from ME squashes the queue and every in-flight request. DE back-pressure replaces the old latch enable/clear stall scheme.

## Interface
- PC_W, 32, PC width (word address).
- INSTR_W, 32, instruction width.
- DEPTH, 4, queue entries and maximum in-flight requests; power of two, >= 2.
- RESET_PC, 0, first fetch address after reset.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect_i  in  1  ME branch taken; squash and refetch.
- redirect_pc_i  in  PC_W  redirect target.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  PC_W  fetch address.
- imem_rsp_valid_i  in  1  response valid (in order, always accepted).
- imem_rsp_data_i  in  INSTR_W  fetched instruction.
- de_valid_o  out  1  queue head valid.
- de_ready_i  in  1  DE consumes head.
- de_instr_o  out  INSTR_W  head instruction.
- de_pc_o  out  PC_W  head PC.
- de_pc_plus1_o  out  PC_W  de_pc_o + 1 (mod 2^PC_W).

## Operation
- State: fetch_pc, rsp_pc (PC of next expected non-stale response), outstanding counter, drop counter, circular queue (wr/rd pointers, count), all counters clog2(DEPTH)+1 bits.
- Reset values: fetch_pc = rsp_pc = RESET_PC, all counters/pointers 0; imem_req_valid_o = 0, imem_req_addr_o = RESET_PC, de_valid_o = 0, de_instr_o/de_pc_o = 0.
- Request: imem_req_valid_o = (outstanding + drop + count < DEPTH) from registered values; addr = fetch_pc. req_fire = valid & ready -> fetch_pc += 1, outstanding += 1. Valid stays asserted with stable addr until accepted unless a redirect occurs.
- Response: rsp_fire with drop > 0 -> discard, drop -= 1. Otherwise push {imem_rsp_data_i, rsp_pc}, rsp_pc += 1, outstanding -= 1. Credit rule guarantees push never overflows; rsp_fire with outstanding = drop = 0 is a protocol error (assertion).
- Pop: de_valid_o = count != 0; pop on de_valid_o & de_ready_i. Freed slot becomes a credit the following cycle.
- Redirect (highest priority): queue cleared (pointers/count 0, de_valid_o 0 next cycle); fetch_pc = rsp_pc = redirect_pc_i; drop_next = drop + outstanding + req_fire - rsp_fire; outstanding = 0. A request accepted or response arriving in the redirect cycle is stale. Pop in redirect cycle is still a valid consumption by DE.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- PC arithmetic wraps modulo 2^PC_W.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); in-flight memory responses after reset release are the memory's responsibility to drop.

## Timing
- Request accepted cycle N, response cycle N+L (L >= 1); entry visible on de_valid_o at N+L+1 (no bypass).
- Redirect at cycle R: de_valid_o = 0 at R+1; imem_req_addr_o = redirect_pc_i at R+1, valid if credits allow.
- Sustained one instruction per cycle when DEPTH >= L + 2 and de_ready_i held high.
- No combinational path from any input to imem_req_valid_o or de_valid_o.

## Test plan
- Reset release, L=1, de_ready_i=1, memory returns addr as data: requests 0,1,2,...; de_pc_o/de_instr_o 0,1,2 from cycle 3 onward, one per cycle; de_pc_plus1_o = de_pc_o+1.
- de_ready_i=0, L=1, DEPTH=4: exactly 4 requests issued, then imem_req_valid_o=0; queue holds PCs 0..3; release ready -> drains in order, fetch resumes at 4.
- imem_req_ready_i toggled 1-0-1: imem_req_addr_o held stable while not ready; no PC skipped or duplicated.
- L=3, 3 requests in flight (PCs 5,6,7), redirect to 0x40 in the cycle PC 5 returns: PCs 5,6,7 never reach DE; first de_pc_o = 0x40.
- Redirect in same cycle as req_fire and pop: popped entry counted consumed; accepted request dropped; drop counter returns to 0 and credits fully restored.
- Reset asserted asynchronously with full queue: de_valid_o and imem_req_valid_o fall without a clock edge; after release fetch restarts at RESET_PC.
